sdram_fifo_sched: RTL and testbench
===================================

# sdram_fifo_sched

Buffering request scheduler that sits directly upstream of `sdram_ctrl`. Decouples a user write stream and a user read stream from the SDRAM via two internal 16-bit FIFOs. Issues fixed-length write bursts when enough data is buffered, and read-prefetch bursts when enough space is free. Generates linear, wrapping burst addresses and drives the `wr_req`/`rd_req` + ack handshakes of the controller.

## Interface
- `BURST_LEN`, 10'd256: words per SDRAM burst (1..512), driven on `wr_burst_len`/`rd_burst_len`.
- `FIFO_DEPTH`, 1024: words per internal FIFO (power of two, ≥ 2·BURST_LEN).
- `BASE_ADDR`, 24'h000000: first word address of the ring region.
- `REGION_WORDS`, 24'h010000: ring size in words (multiple of BURST_LEN).

Ports:
- `clk` in 1: system clock, same as `sdram_ctrl`.
- `rst` in 1: reset, asynchronous, active-high.
- `usr_wr_valid` in 1: push `usr_wr_data` into the write FIFO.
- `usr_wr_data` in 16: user write word.
- `usr_wr_full` out 1: write FIFO full; pushes while full are dropped.
- `usr_rd_en` in 1: enables read prefetch.
- `usr_rd_pop` in 1: pop the read FIFO.
- `usr_rd_data` out 16: popped word, registered.
- `usr_rd_empty` out 1: read FIFO empty; pops while empty are ignored.
- `wr_req` out 1: write request to the controller.
- `wr_addr` out 24: burst start address.
- `wr_data` out 16: word for the controller.
- `wr_burst_len` out 10: constant BURST_LEN.
- `wr_ack` in 1: controller consumes the next word; the word must be on `wr_data` in the following cycle.
- `rd_req` out 1: read request to the controller.
- `rd_addr` out 24: burst start address.
- `rd_burst_len` out 10: constant BURST_LEN.
- `rd_ack` in 1: `rd_data` valid this cycle.
- `rd_data` in 16: word from the controller.

## Operation
- FSM states:
  - IDLE → WRITE, when the write-eligible condition (`wr_level ≥ BURST_LEN`) holds.
  - IDLE → READ, when the read-eligible condition holds: `usr_rd_en` and `avail_bursts > 0` and `rd_free ≥ BURST_LEN`.
  - WRITE → IDLE, on the BURST_LEN-th `wr_ack`.
  - READ → IDLE, on the BURST_LEN-th `rd_ack`.
- Only one burst is outstanding at a time.
- Arbitration when both conditions hold in IDLE: round-robin via a `last_was_write` flag (reset 0). Write wins if the flag is 0, read wins if it is 1. The flag updates on each grant.
- WRITE state:
  - `wr_req`=1 and `wr_addr`=`wptr`.
  - Each `wr_ack` pops the write FIFO. The registered FIFO output drives `wr_data` in the next cycle.
  - A 10-bit `beat_cnt` counts acks.
  - On the last ack: `wr_req` is cleared (low next cycle), `wptr` += BURST_LEN, `avail_bursts` += 1.
- READ state:
  - `rd_req`=1 and `rd_addr`=`rptr`.
  - Each `rd_ack` pushes `rd_data` into the read FIFO.
  - On the last ack: `rd_req` is cleared, `rptr` += BURST_LEN, `avail_bursts` -= 1.
- Pointer wrap: when `ptr + BURST_LEN == BASE_ADDR + REGION_WORDS`, the pointer reloads BASE_ADDR.
- `avail_bursts`:
  - Width is log2(REGION_WORDS/BURST_LEN)+1.
  - Saturates at REGION_WORDS/BURST_LEN. At saturation, further completed write bursts overwrite the oldest data and `rptr` advances with `wptr` so that the oldest unread burst is skipped.
- Read FIFO overflow is impossible by the `rd_free` check at issue. `rd_free` = FIFO_DEPTH − `rd_level`.
- `usr_rd_en` deasserted mid-burst does not abort the burst; it only blocks new read issues.
- Simultaneous user push and pop on the same FIFO are both honoured and the level is unchanged.

## Timing
- Reset values:
  - `wr_req`=0, `rd_req`=0, `wr_data`=0, `usr_rd_data`=0, `usr_rd_empty`=1, `usr_wr_full`=0.
  - `wr_addr`=`rd_addr`=BASE_ADDR.
  - FIFOs empty, FSM in IDLE, counters 0.
- Request latency: eligibility is evaluated in IDLE, and `wr_req`/`rd_req` rises at the next clock edge.
- Request hold: the request stays high, with the address stable, until the cycle after the final ack.
- After a burst completes, the FSM spends ≥1 cycle in IDLE before issuing the next request.
- Write data: `wr_ack` in cycle N → word k on `wr_data` in cycle N+1. With BURST_LEN acks, all words are delivered back-to-back.
- Read data: `rd_ack` in cycle N → word written into the read FIFO at edge N. Visible to a pop from N+1.
- User pop: `usr_rd_pop` in cycle N → `usr_rd_data` updated at edge N+1.
- `usr_wr_full`/`usr_rd_empty` are registered and reflect the level after the current edge.
- Reset mid-burst: requests drop immediately (asynchronously), all buffered data is discarded, and pointers return to BASE_ADDR.

## Test plan
- Write burst: BURST_LEN=4; push 4 words 0x0001..0x0004.
  - `wr_req` rises at the next edge with `wr_addr`=0.
  - The bench acks 4 times; `wr_data` = 1,2,3,4 on the cycles after each ack.
  - `wr_req` is low after the 4th ack, and the next `wr_addr`=4.
- Readback: after the write burst, assert `usr_rd_en`.
  - `rd_req` rises with `rd_addr`=0.
  - Bench returns 0xA0..0xA3 with `rd_ack`; 4 pops yield 0xA0..0xA3, and `usr_rd_empty` returns to 1.
- Arbitration: keep ≥4 words buffered and `avail_bursts`>0 with `usr_rd_en`=1 → grants alternate W,R,W,R starting with W.
- Wrap: REGION_WORDS=8, BURST_LEN=4; perform 3 write bursts.
  - Write addresses are 0,4,0.
  - `avail_bursts` saturates at 2, and `rptr` is skipped to 4.
- Boundaries:
  - Fill the write FIFO to FIFO_DEPTH → `usr_wr_full`=1, and an extra push is dropped (the level stays FIFO_DEPTH).
  - With `rd_level` > FIFO_DEPTH−BURST_LEN, no `rd_req` is issued.
- Reset: assert `rst` in the middle of a write burst (after 2 acks) → `wr_req`=0 immediately; after release, `wr_addr`=BASE_ADDR and the FIFOs are empty.

Source files
------------

// File: rtl/sdram_fifo_sched.sv
// Buffering scheduler in front of sdram_ctrl: a user write FIFO drained in fixed
// bursts and a read FIFO filled by prefetch bursts over a wrapping ring region.
module sdram_fifo_sched #(
  parameter int unsigned BURST_LEN    = 256,
  parameter int unsigned FIFO_DEPTH   = 1024,
  parameter logic [23:0] BASE_ADDR    = 24'h000000,
  parameter logic [23:0] REGION_WORDS = 24'h010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usr_wr_valid,
  input  logic [15:0] usr_wr_data,
  output logic        usr_wr_full,
  input  logic        usr_rd_en,
  input  logic        usr_rd_pop,
  output logic [15:0] usr_rd_data,
  output logic        usr_rd_empty,
  output logic        wr_req,
  output logic [23:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [9:0]  wr_burst_len,
  input  logic        wr_ack,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [9:0]  rd_burst_len,
  input  logic        rd_ack,
  input  logic [15:0] rd_data
);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = PW + 1;
  localparam int unsigned NBURSTS = 32'(REGION_WORDS) / BURST_LEN;
  localparam int unsigned AVW     = $clog2(NBURSTS) + 1;

  localparam logic [LW-1:0]  BL_LVL    = LW'(BURST_LEN);
  localparam logic [LW-1:0]  DEPTH_LVL = LW'(FIFO_DEPTH);
  localparam logic [23:0]    BL_ADDR   = 24'(BURST_LEN);
  localparam logic [23:0]    END_ADDR  = BASE_ADDR + REGION_WORDS;
  localparam logic [AVW-1:0] AVAIL_MAX = AVW'(NBURSTS);
  localparam logic [9:0]     LAST_BEAT = 10'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

  function automatic logic [23:0] next_ptr(input logic [23:0] p);
    return (p + BL_ADDR == END_ADDR) ? BASE_ADDR : p + BL_ADDR;
  endfunction

  state_e         state_q, state_d;
  logic [9:0]     beat_cnt_q, beat_cnt_d;
  logic [23:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AVW-1:0] avail_q, avail_d;
  logic           last_wr_q, last_wr_d;

  logic [15:0]    wf_mem [FIFO_DEPTH];
  logic [PW-1:0]  wf_wp_q, wf_rp_q;
  logic [LW-1:0]  wf_lvl_q, wf_lvl_d;
  logic           wf_full_q;
  logic [15:0]    wf_dout_q;

  logic [15:0]    rf_mem [FIFO_DEPTH];
  logic [PW-1:0]  rf_wp_q, rf_rp_q;
  logic [LW-1:0]  rf_lvl_q, rf_lvl_d;
  logic           rf_empty_q;
  logic [15:0]    rf_dout_q;

  logic wf_push, wf_pop, rf_push, rf_pop;
  logic wr_done, rd_done, wr_elig, rd_elig;

  assign wf_push = usr_wr_valid && !wf_full_q;
  assign wf_pop  = (state_q == S_WRITE) && wr_ack && (wf_lvl_q != '0);
  assign rf_push = (state_q == S_READ) && rd_ack && (rf_lvl_q != DEPTH_LVL);
  assign rf_pop  = usr_rd_pop && !rf_empty_q;

  assign wf_lvl_d = wf_lvl_q + LW'(wf_push) - LW'(wf_pop);
  assign rf_lvl_d = rf_lvl_q + LW'(rf_push) - LW'(rf_pop);

  assign wr_done = (state_q == S_WRITE) && wr_ack && (beat_cnt_q == LAST_BEAT);
  assign rd_done = (state_q == S_READ) && rd_ack && (beat_cnt_q == LAST_BEAT);
  assign wr_elig = wf_lvl_q >= BL_LVL;
  assign rd_elig = usr_rd_en && (avail_q != '0) && ((DEPTH_LVL - rf_lvl_q) >= BL_LVL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_elig && rd_elig) state_d = last_wr_q ? S_READ : S_WRITE;
        else if (wr_elig)       state_d = S_WRITE;
        else if (rd_elig)       state_d = S_READ;
      end
      S_WRITE: if (wr_done) state_d = S_IDLE;
      S_READ:  if (rd_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_req = 1'b0;
    rd_req = 1'b0;
    unique case (state_q)
      S_WRITE: wr_req = 1'b1;
      S_READ:  rd_req = 1'b1;
      default: ;
    endcase
  end

  // A completed write into a full ring drops the oldest unread burst.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    avail_d    = avail_q;
    last_wr_d  = last_wr_q;
    if (wr_done || rd_done) beat_cnt_d = '0;
    else if (((state_q == S_WRITE) && wr_ack) || ((state_q == S_READ) && rd_ack))
      beat_cnt_d = beat_cnt_q + 10'd1;
    if (wr_done) begin
      wptr_d = next_ptr(wptr_q);
      if (avail_q == AVAIL_MAX) rptr_d = next_ptr(rptr_q);
      else                      avail_d = avail_q + AVW'(1);
    end
    if (rd_done) begin
      rptr_d  = next_ptr(rptr_q);
      avail_d = avail_q - AVW'(1);
    end
    if (state_q == S_IDLE && state_d == S_WRITE) last_wr_d = 1'b1;
    if (state_q == S_IDLE && state_d == S_READ)  last_wr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      wptr_q     <= BASE_ADDR;
      rptr_q     <= BASE_ADDR;
      avail_q    <= '0;
      last_wr_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      avail_q    <= avail_d;
      last_wr_q  <= last_wr_d;
    end
  end

  // NOTE: storage arrays are not reset; levels and pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wf_push) wf_mem[wf_wp_q] <= usr_wr_data;
    if (rf_push) rf_mem[rf_wp_q] <= rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wf_wp_q    <= '0;
      wf_rp_q    <= '0;
      wf_lvl_q   <= '0;
      wf_full_q  <= 1'b0;
      wf_dout_q  <= '0;
      rf_wp_q    <= '0;
      rf_rp_q    <= '0;
      rf_lvl_q   <= '0;
      rf_empty_q <= 1'b1;
      rf_dout_q  <= '0;
    end else begin
      if (wf_push) wf_wp_q <= wf_wp_q + PW'(1);
      if (wf_pop) begin
        wf_rp_q   <= wf_rp_q + PW'(1);
        wf_dout_q <= wf_mem[wf_rp_q];
      end
      wf_lvl_q  <= wf_lvl_d;
      wf_full_q <= (wf_lvl_d == DEPTH_LVL);
      if (rf_push) rf_wp_q <= rf_wp_q + PW'(1);
      if (rf_pop) begin
        rf_rp_q   <= rf_rp_q + PW'(1);
        rf_dout_q <= rf_mem[rf_rp_q];
      end
      rf_lvl_q   <= rf_lvl_d;
      rf_empty_q <= (rf_lvl_d == '0);
    end
  end

  assign usr_wr_full  = wf_full_q;
  assign usr_rd_empty = rf_empty_q;
  assign usr_rd_data  = rf_dout_q;
  assign wr_data      = wf_dout_q;
  assign wr_addr      = wptr_q;
  assign rd_addr      = rptr_q;
  assign wr_burst_len = 10'(BURST_LEN);
  assign rd_burst_len = 10'(BURST_LEN);

endmodule

// File: tb/tb_sdram_fifo_sched.sv
// Directed bench for sdram_fifo_sched: BURST_LEN=4, 8-word FIFOs, 8-word ring at 0.
module tb_sdram_fifo_sched;
  localparam int unsigned BL    = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        usr_wr_valid, usr_rd_en, usr_rd_pop, wr_ack, rd_ack;
  logic [15:0] usr_wr_data, rd_data;
  logic        usr_wr_full, usr_rd_empty, wr_req, rd_req;
  logic [15:0] usr_rd_data, wr_data;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_fifo_sched #(
    .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .BASE_ADDR(24'h000000), .REGION_WORDS(24'd8)
  ) dut (
    .clk(clk), .rst(rst),
    .usr_wr_valid(usr_wr_valid), .usr_wr_data(usr_wr_data), .usr_wr_full(usr_wr_full),
    .usr_rd_en(usr_rd_en), .usr_rd_pop(usr_rd_pop), .usr_rd_data(usr_rd_data),
    .usr_rd_empty(usr_rd_empty),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_burst_len(wr_burst_len),
    .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_ack(rd_ack),
    .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    usr_wr_valid = 1'b0; usr_wr_data = '0; usr_rd_en = 1'b0; usr_rd_pop = 1'b0;
    wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    usr_wr_valid = 1'b1;
    usr_wr_data  = d;
    @(negedge clk);
    usr_wr_valid = 1'b0;
  endtask

  task automatic pop();
    usr_rd_pop = 1'b1;
    @(negedge clk);
    usr_rd_pop = 1'b0;
  endtask

  task automatic expect_no_rd(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rd_req) seen++;
    end
    check(tag, 32'(seen), 0);
  endtask

  // Waits for the next grant, checks its kind and address, then completes the burst.
  task automatic serve(input string tag, input bit exp_wr, input logic [23:0] exp_addr,
                       input logic [15:0] base);
    int n = 0;
    bit is_wr;
    bit held = 1'b1;
    while (!(wr_req || rd_req) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, 32'(wr_req || rd_req), 1);
    if (!(wr_req || rd_req)) return;
    is_wr = wr_req;
    check({tag, "_kind"}, 32'(is_wr), 32'(exp_wr));
    check({tag, "_addr"}, 32'(is_wr ? wr_addr : rd_addr), 32'(exp_addr));
    for (int k = 0; k < BL; k++) begin
      if (is_wr) wr_ack = 1'b1;
      else begin
        rd_ack  = 1'b1;
        rd_data = base + 16'(k);
      end
      @(negedge clk);
      if (is_wr) check({tag, "_wr_data"}, 32'(wr_data), 32'(base + 16'(k)));
      if (k < BL - 1 && !(is_wr ? wr_req : rd_req)) held = 1'b0;
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    check({tag, "_req_held"}, 32'(held), 1);
    check({tag, "_req_drop"}, 32'(wr_req || rd_req), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_wr_req", 32'(wr_req), 0);
    check("rst_rd_req", 32'(rd_req), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_usr_rd_data", 32'(usr_rd_data), 0);
    check("rst_rd_empty", 32'(usr_rd_empty), 1);
    check("rst_wr_full", 32'(usr_wr_full), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("wr_burst_len", 32'(wr_burst_len), BL);
    check("rd_burst_len", 32'(rd_burst_len), BL);

    // Single write burst with exact request latency.
    for (int i = 1; i <= 4; i++) push(16'(i));
    check("b_req_not_early", 32'(wr_req), 0);
    @(negedge clk);
    check("b_req_rise", 32'(wr_req), 1);
    check("b_wr_addr", 32'(wr_addr), 0);
    serve("b", 1'b1, 24'd0, 16'h0001);
    check("b_next_addr", 32'(wr_addr), 4);

    // Readback of the burst just written.
    usr_rd_en = 1'b1;
    @(negedge clk);
    check("c_req_rise", 32'(rd_req), 1);
    check("c_rd_addr", 32'(rd_addr), 0);
    usr_rd_en = 1'b0;
    serve("c", 1'b0, 24'd0, 16'h00A0);
    check("c_next_addr", 32'(rd_addr), 4);
    check("c_not_empty", 32'(usr_rd_empty), 0);
    for (int k = 0; k < 4; k++) begin
      pop();
      check("c_pop_data", 32'(usr_rd_data), 32'(16'h00A0 + 16'(k)));
    end
    check("c_empty_again", 32'(usr_rd_empty), 1);

    // Round-robin when both conditions hold.
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    usr_rd_en = 1'b1;
    serve("d1", 1'b1, 24'd0, 16'h0001);
    serve("d2", 1'b0, 24'd0, 16'h00A0);
    serve("d3", 1'b1, 24'd4, 16'h0005);
    serve("d4", 1'b0, 24'd4, 16'h00B0);

    // Full write FIFO drops extra pushes; read issue blocked by low free space.
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'h0100 + 16'(i));
    check("e_full", 32'(usr_wr_full), 1);
    push(16'hDEAD);
    check("e_full_hold", 32'(usr_wr_full), 1);
    serve("e_w1", 1'b1, 24'd0, 16'h0101);
    check("e_not_full", 32'(usr_wr_full), 0);
    serve("e_w2", 1'b1, 24'd4, 16'h0105);
    usr_rd_en = 1'b1;
    serve("e_r1", 1'b0, 24'd0, 16'h00C0);
    serve("e_r2", 1'b0, 24'd4, 16'h00D0);
    for (int i = 1; i <= 4; i++) push(16'h0200 + 16'(i));
    serve("e_w3", 1'b1, 24'd0, 16'h0201);
    expect_no_rd("e_blocked_lvl8", 6);
    for (int k = 0; k < 3; k++) begin
      pop();
      check("e_pop_data", 32'(usr_rd_data), 32'(16'h00C0 + 16'(k)));
    end
    expect_no_rd("e_blocked_lvl5", 6);
    pop();
    check("e_pop_data3", 32'(usr_rd_data), 32'h00C3);
    serve("e_r3", 1'b0, 24'd0, 16'h00E0);

    // Ring wrap and saturation of available bursts.
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
    serve("f_w1", 1'b1, 24'd0, 16'h0010);
    for (int i = 0; i < 4; i++) push(16'h0020 + 16'(i));
    serve("f_w2", 1'b1, 24'd4, 16'h0020);
    for (int i = 0; i < 4; i++) push(16'h0030 + 16'(i));
    serve("f_w3", 1'b1, 24'd0, 16'h0030);
    check("f_wptr", 32'(wr_addr), 4);
    check("f_rptr_skipped", 32'(rd_addr), 4);
    usr_rd_en = 1'b1;
    serve("f_r1", 1'b0, 24'd4, 16'h0300);
    serve("f_r2", 1'b0, 24'd0, 16'h0400);
    for (int k = 0; k < 8; k++) begin
      pop();
      check("f_pop_data", 32'(usr_rd_data),
            32'(k < 4 ? 16'h0300 + 16'(k) : 16'h0400 + 16'(k - 4)));
    end
    check("f_empty", 32'(usr_rd_empty), 1);
    expect_no_rd("f_avail_sat", 10);

    // Reset in the middle of a write burst.
    usr_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0500 + 16'(i));
    @(negedge clk);
    check("g_req_up", 32'(wr_req), 1);
    check("g_addr", 32'(wr_addr), 4);
    wr_ack = 1'b1;
    repeat (2) @(negedge clk);
    wr_ack = 1'b0;
    check("g_mid_data", 32'(wr_data), 32'h0501);
    rst = 1'b1;
    #1;
    check("g_async_drop", 32'(wr_req), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("g_wr_addr_base", 32'(wr_addr), 0);
    check("g_rd_addr_base", 32'(rd_addr), 0);
    check("g_wr_not_full", 32'(usr_wr_full), 0);
    check("g_rd_empty", 32'(usr_rd_empty), 1);
    push(16'h0600);
    push(16'h0601);
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (wr_req) seen++;
      end
      check("g_wfifo_flushed", 32'(seen), 0);
    end
    push(16'h0602);
    push(16'h0603);
    serve("g_after", 1'b1, 24'd0, 16'h0600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
